// File: rtl/arb_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding, default
// bus dimensions and the one-hot helper used to build the grant vector.
package arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    localparam int NREQ_DEF = 3;
    localparam int AW_DEF   = 10;
    localparam int DW_DEF   = 32;
    localparam int OWNER_W  = 2;
    localparam int PERF_W   = 32;

    // Expand an owner index into a 4-bit one-hot vector; callers slice to NREQ.
    function automatic logic [3:0] onehot4(input logic [OWNER_W-1:0] idx);
        logic [3:0] oh;
        oh = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Round-robin winner selection. Scans requesters starting at ptr+1 and
// wrapping, so the requester at ptr is considered last. An optional
// exclusion removes the current owner from the scan when looking for a
// different requester to hand off to.
module rr_picker
    import arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]    req,
    input  logic [OWNER_W-1:0] ptr,
    input  logic               excl_en,
    input  logic [OWNER_W-1:0] excl,
    output logic               valid,
    output logic [OWNER_W-1:0] winner
);

    // First eligible requester after ptr in cyclic order.
    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!valid && req[idx] && !(excl_en && (int'(excl) == idx))) begin
                valid  = 1'b1;
                winner = OWNER_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (async read, sync write)
// among NREQ requesters. Supports lock for atomic sequences and a bounded
// hold time for unlocked owners when others are waiting.
// Optional feature macro: ARB_PERF_EN enables per-requester granted-cycle
// counters on perf_cnt; without it perf_cnt is tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no grant; first pending requester after ptr wins next edge
// ST_GRANT | owner holds the RAM; release, handoff or preempt per edge
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        lock,
    input  logic [NREQ-1:0]        we,
    input  logic [NREQ*AW-1:0]     addr,
    input  logic [NREQ*DW-1:0]     wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [DW-1:0]          rdata,
    output logic [OWNER_W-1:0]     owner,
    output logic                   busy,
    output logic [AW-1:0]          mem_a,
    output logic [DW-1:0]          mem_d,
    output logic                   mem_we,
    input  logic [DW-1:0]          mem_spo,
    output logic [NREQ*PERF_W-1:0] perf_cnt
);

    // Hold counter only needs to reach MAX_HOLD-1, where it saturates.
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam bit PREEMPT_EN = (MAX_HOLD != 0);

    arb_state_t          state_q, state_nx;
    logic [OWNER_W-1:0]  owner_q, owner_nx;
    logic [OWNER_W-1:0]  ptr_q, ptr_nx;
    logic [HOLD_W-1:0]   hold_q, hold_nx;
    logic [NREQ-1:0]     gnt_q, gnt_nx;

    logic                owner_req;
    logic                owner_lock;
    logic                owner_we;
    logic [AW-1:0]       owner_addr;
    logic [DW-1:0]       owner_wdata;

    logic                in_grant;
    logic [OWNER_W-1:0]  pick_ptr;
    logic                pick_valid;
    logic [OWNER_W-1:0]  pick_winner;

    // In GRANT the scan starts after the current owner and skips it, so a
    // handoff always goes to a different requester in round-robin order.
    assign in_grant = (state_q == ST_GRANT);
    assign pick_ptr = in_grant ? owner_q : ptr_q;

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req     (req),
        .ptr     (pick_ptr),
        .excl_en (in_grant),
        .excl    (owner_q),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    // Select the owner's request lines and bus slices.
    always_comb begin
        owner_req   = 1'b0;
        owner_lock  = 1'b0;
        owner_we    = 1'b0;
        owner_addr  = '0;
        owner_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == OWNER_W'(i)) begin
                owner_req   = req[i];
                owner_lock  = lock[i];
                owner_we    = we[i];
                owner_addr  = addr[i*AW +: AW];
                owner_wdata = wdata[i*DW +: DW];
            end
        end
    end

    // Next-state, owner, round-robin pointer, hold counter and grant vector.
    always_comb begin
        logic [3:0] oh;
        state_nx = state_q;
        owner_nx = owner_q;
        ptr_nx   = ptr_q;
        hold_nx  = hold_q;
        gnt_nx   = '0;
        oh       = 4'b0000;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_nx = ST_GRANT;
                    owner_nx = pick_winner;
                    hold_nx  = '0;
                end
            end
            ST_GRANT: begin
                if (!owner_req) begin
                    ptr_nx  = owner_q;
                    hold_nx = '0;
                    if (pick_valid) begin
                        owner_nx = pick_winner;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end else if (PREEMPT_EN && !owner_lock && (hold_q >= HOLD_SAT) && pick_valid) begin
                    ptr_nx   = owner_q;
                    owner_nx = pick_winner;
                    hold_nx  = '0;
                end else if (hold_q < HOLD_SAT) begin
                    hold_nx = hold_q + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        oh = onehot4(owner_nx);
        if (state_nx == ST_GRANT) begin
            gnt_nx = oh[NREQ-1:0];
        end
    end

    // Arbitration registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= OWNER_W'(NREQ - 1);
            hold_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_nx;
            owner_q <= owner_nx;
            ptr_q   <= ptr_nx;
            hold_q  <= hold_nx;
            gnt_q   <= gnt_nx;
        end
    end

    assign gnt   = gnt_q;
    assign busy  = in_grant;
    assign owner = owner_q;
    assign rdata = mem_spo;

    // RAM port mux: only the owner's slice reaches the RAM; rstn gates the
    // write so nothing is written in a reset cycle.
    always_comb begin
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (in_grant) begin
            mem_a  = owner_addr;
            mem_d  = owner_wdata;
            mem_we = owner_we & rstn;
        end
    end

`ifdef ARB_PERF_EN
    logic [PERF_W-1:0] perf_q [NREQ];

    // Granted-cycle counters, free-running with natural wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                perf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_q[i]) begin
                    perf_q[i] <= perf_q[i] + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        assign perf_cnt[g*PERF_W +: PERF_W] = perf_q[g];
    end
`else
    assign perf_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (NREQ=3, MAX_HOLD=8) with a behavioural
// 1024x32 RAM. Each task drives one scenario and checks inline.
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 10;
    localparam int DW   = 32;
`ifdef ARB_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic               clk;
    logic               rstn;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ-1:0]    we;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [DW-1:0]      rdata;
    logic [1:0]         owner;
    logic               busy;
    logic [AW-1:0]      mem_a;
    logic [DW-1:0]      mem_d;
    logic               mem_we;
    logic [DW-1:0]      mem_spo;
    logic [NREQ*32-1:0] perf_cnt;

    logic [31:0] ram [0:1023];
    logic        ram_clear;

    int total;
    int bad;

    mem_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .MAX_HOLD (8)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req      (req),
        .lock     (lock),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rdata    (rdata),
        .owner    (owner),
        .busy     (busy),
        .mem_a    (mem_a),
        .mem_d    (mem_d),
        .mem_we   (mem_we),
        .mem_spo  (mem_spo),
        .perf_cnt (perf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: async read, sync write, fill pattern on ram_clear.
    assign mem_spo = ram[mem_a];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hA500_0000 | i;
        end else if (mem_we) begin
            ram[mem_a] <= mem_d;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req = '0; lock = '0; we = '0;
        tick(); tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
        ram_clear = 1'b1;
        tick(); tick();
        ram_clear = 1'b0;
        rstn = 1'b1;
        #1;
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        total++; if (mem_a !== 10'd0) begin bad++; $display("FAIL reset_mem_a got=%0d exp=0", mem_a); end
        total++; if (perf_cnt !== '0) begin bad++; $display("FAIL reset_perf got=%h exp=0", perf_cnt); end
    endtask

    task automatic test_write_read();
        addr[1*AW +: AW]  = 10'd5;
        wdata[1*DW +: DW] = 32'hDEAD_BEEF;
        we  = 3'b010;
        req = 3'b010;
        #1;
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL wr_latency gnt got=%b exp=000", gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL wr_idle_we got=%b exp=0", mem_we); end
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL wr_gnt got=%b exp=010", gnt); end
        total++; if (owner !== 2'd1) begin bad++; $display("FAIL wr_owner got=%0d exp=1", owner); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy got=%b exp=1", busy); end
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wr_mem_we got=%b exp=1", mem_we); end
        total++; if (mem_a !== 10'd5) begin bad++; $display("FAIL wr_mem_a got=%0d exp=5", mem_a); end
        total++; if (mem_d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_mem_d got=%h exp=deadbeef", mem_d); end
        tick();
        we = 3'b000;
        #1;
        total++; if (ram[5] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_ram5 got=%h exp=deadbeef", ram[5]); end
        total++; if (rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rd_mem_we got=%b exp=0", mem_we); end
        req = 3'b000;
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL wr_release gnt got=%b exp=000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_release busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_gnt [7];
        logic [2:0] req_after [7];
        logic [31:0] exp_perf;
        exp_gnt   = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000};
        req_after = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000};
        do_reset();
        req = 3'b111;
        for (int k = 0; k < 7; k++) begin
            tick();
            total++;
            if (gnt !== exp_gnt[k]) begin
                bad++; $display("FAIL rr_step%0d gnt got=%b exp=%b", k, gnt, exp_gnt[k]);
            end
            req = req_after[k];
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_busy_end got=%b exp=0", busy); end
        exp_perf = PERF_ON ? 32'd2 : 32'd0;
        for (int i = 0; i < NREQ; i++) begin
            total++;
            if (perf_cnt[i*32 +: 32] !== exp_perf) begin
                bad++; $display("FAIL rr_perf%0d got=%0d exp=%0d", i, perf_cnt[i*32 +: 32], exp_perf);
            end
        end
    endtask

    task automatic test_preempt();
        req = 3'b001; lock = 3'b000;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL pre_first gnt got=%b exp=001", gnt); end
        req = 3'b011;
        for (int c = 2; c <= 8; c++) begin
            tick();
            total++;
            if (gnt !== 3'b001) begin bad++; $display("FAIL pre_hold%0d gnt got=%b exp=001", c, gnt); end
        end
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL pre_handoff gnt got=%b exp=010", gnt); end
        total++; if (owner !== 2'd1) begin bad++; $display("FAIL pre_owner got=%0d exp=1", owner); end
        tick();
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL pre_g1_hold gnt got=%b exp=010", gnt); end
        req = 3'b001;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL pre_back0 gnt got=%b exp=001", gnt); end
        req = 3'b000;
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL pre_idle gnt got=%b exp=000", gnt); end
    endtask

    task automatic test_lock();
        req = 3'b001; lock = 3'b001;
        tick();
        total++; if (gnt !== 3'b001) begin bad++; $display("FAIL lock_first gnt got=%b exp=001", gnt); end
        req = 3'b101;
        for (int c = 2; c <= 20; c++) begin
            tick();
            total++;
            if (gnt !== 3'b001) begin bad++; $display("FAIL lock_hold%0d gnt got=%b exp=001", c, gnt); end
        end
        lock = 3'b000;
        tick();
        total++; if (gnt !== 3'b100) begin bad++; $display("FAIL lock_release gnt got=%b exp=100", gnt); end
        req = 3'b000;
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL lock_idle gnt got=%b exp=000", gnt); end
    endtask

    task automatic test_nonowner_we();
        addr[2*AW +: AW]  = 10'd7;
        wdata[2*DW +: DW] = 32'h0BAD_0BAD;
        addr[1*AW +: AW]  = 10'd3;
        we  = 3'b100;
        req = 3'b010;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL nw_idle_we got=%b exp=0", mem_we); end
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL nw_gnt got=%b exp=010", gnt); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL nw_mem_we got=%b exp=0", mem_we); end
        total++; if (mem_a !== 10'd3) begin bad++; $display("FAIL nw_mem_a got=%0d exp=3", mem_a); end
        tick(); tick();
        total++; if (ram[7] !== 32'hA500_0007) begin bad++; $display("FAIL nw_ram7 got=%h exp=a5000007", ram[7]); end
        req = 3'b000; we = 3'b000;
        tick();
    endtask

    task automatic test_reset_midgrant();
        addr[1*AW +: AW]  = 10'd9;
        wdata[1*DW +: DW] = 32'h0000_0055;
        we  = 3'b010;
        req = 3'b010;
        tick();
        total++; if (gnt !== 3'b010) begin bad++; $display("FAIL rm_gnt got=%b exp=010", gnt); end
        tick();
        total++; if (ram[9] !== 32'h0000_0055) begin bad++; $display("FAIL rm_ram9 got=%h exp=00000055", ram[9]); end
        rstn = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rm_we_in_reset got=%b exp=0", mem_we); end
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rm_gnt_after got=%b exp=000", gnt); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL rm_owner got=%0d exp=0", owner); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rm_mem_we got=%b exp=0", mem_we); end
        total++; if (perf_cnt !== '0) begin bad++; $display("FAIL rm_perf got=%h exp=0", perf_cnt); end
        rstn = 1'b1; req = 3'b000; we = 3'b000;
        tick();
        total++; if (gnt !== 3'b000) begin bad++; $display("FAIL rm_post gnt got=%b exp=000", gnt); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_write_read();
        test_round_robin();
        test_preempt();
        test_lock();
        test_nonowner_we();
        test_reset_midgrant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
